// File: rtl/q_input_scheduler.sv
// q_input_scheduler
// Two 8-bit unsigned integer streams share one integer-to-Q-format conversion
// path. A round-robin arbiter keeps a grant locked for a whole burst. Each
// accepted beat is converted and written into a single output register, which
// drives one tagged valid/ready stream.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   reqX_valid/data/last/ready    requester X beat stream (X = 0 activations, 1 weights)
//   out_valid/data/src/last       converted word, its source and end-of-burst flag
//   out_ready                     downstream accept
//   busy                          a grant is active
module q_input_scheduler #(
  parameter int N         = 20,
  parameter int Q         = 11,
  parameter int MAX_BURST = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [7:0]   req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [7:0]   req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_src,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  if (N < Q + 9) begin : g_bad_width
    $error("q_input_scheduler: N must be >= Q+9");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("q_input_scheduler: MAX_BURST must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t     state, state_nxt;
  logic       prio;
  logic [7:0] beat_cnt;

  logic       can_load;
  logic       acc;
  logic [7:0] sel_data;
  logic       sel_last;
  logic       cnt_max;
  logic       burst_end;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (burst_end) begin
        prio     <= (state == GNT0);   // favour the other requester next time
        beat_cnt <= '0;
      end else if (acc) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nxt = prio ? GNT1 : GNT0;
        else if (req0_valid)          state_nxt = GNT0;
        else if (req1_valid)          state_nxt = GNT1;
      end
      GNT0, GNT1: if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- outputs / handshake ----------------
  // Ready depends only on state and the output register, never on reqX_valid.
  always_comb begin
    can_load   = !out_valid || out_ready;
    req0_ready = (state == GNT0) && can_load;
    req1_ready = (state == GNT1) && can_load;
    busy       = (state != IDLE);
  end

  always_comb begin
    sel_data  = (state == GNT1) ? req1_data : req0_data;
    sel_last  = (state == GNT1) ? req1_last : req0_last;
    acc       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    // The MAX_BURST-th beat of a grant is forced to end the burst.
    cnt_max   = (beat_cnt == 8'(MAX_BURST - 1));
    burst_end = acc && (sel_last || cnt_max);
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      // integer lands on bits [Q+7:Q]; sign, fraction and padding stay zero
      out_data  <= {{(N-Q-8){1'b0}}, sel_data, {Q{1'b0}}};
      out_src   <= (state == GNT1);
      out_last  <= sel_last || cnt_max;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_q_input_scheduler.sv
module tb_q_input_scheduler;
  localparam int N  = 20;
  localparam int Q  = 11;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_last, req0_ready;
  logic [7:0]   req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [7:0]   req1_data;
  logic         out_valid, out_src, out_last, out_ready, busy;
  logic [N-1:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  q_input_scheduler #(.N(N), .Q(Q), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, r0v;
    logic [7:0] r0d;
    logic       r0l, r1v;
    logic [7:0] r1d;
    logic       r1l, ordy;
    logic       e0, e1, eov;
    logic [N-1:0] eod;
    logic       esrc, elast, ebusy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic rs, logic a, logic [7:0] ad, logic al,
                              logic b, logic [7:0] bd, logic bl, logic ord,
                              logic e0, logic e1, logic ov, logic [N-1:0] od,
                              logic s, logic l, logic bz);
    vec_t v;
    v.rst = rs; v.r0v = a; v.r0d = ad; v.r0l = al; v.r1v = b; v.r1d = bd; v.r1l = bl;
    v.ordy = ord; v.e0 = e0; v.e1 = e1; v.eov = ov; v.eod = od; v.esrc = s;
    v.elast = l; v.ebusy = bz;
    return v;
  endfunction

  // ---------------- stream scenarios ----------------
  logic [7:0] s0_d[8];  logic s0_l[8];  int s0_n;
  logic [7:0] s1_d[8];  logic s1_l[8];  int s1_n;
  logic       e_src[12]; logic [7:0] e_dat[12]; logic e_lst[12]; int e_n;

  task automatic clr();
    s0_n = 0; s1_n = 0; e_n = 0;
  endtask
  task automatic push0(input logic [7:0] d, input logic l);
    s0_d[s0_n] = d; s0_l[s0_n] = l; s0_n++;
  endtask
  task automatic push1(input logic [7:0] d, input logic l);
    s1_d[s1_n] = d; s1_l[s1_n] = l; s1_n++;
  endtask
  task automatic pushe(input logic s, input logic [7:0] d, input logic l);
    e_src[e_n] = s; e_dat[e_n] = d; e_lst[e_n] = l; e_n++;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs(); out_ready = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // Streams the queued beats, checks every drained word against the expected
  // list, output stability under stall, and that the waiting requester is
  // blocked while req0 sits in a gap of gap_len cycles after beat gap_at.
  task automatic run_stream(input string nm, input logic [7:0] pat, input int gap_at, input int gap_len);
    int i0 = 0, i1 = 0, got = 0, gap = 0, cyc = 0;
    logic pstall = 0, a0, a1, v0;
    logic [N-1:0] pd = '0;
    logic ps = 0, pl = 0;
    logic [N-1:0] ew;
    while ((i0 < s0_n || i1 < s1_n || got < e_n) && cyc < 200) begin
      @(negedge clk);
      out_ready  = pat[cyc % 8];
      v0         = (i0 < s0_n) && (gap == 0);
      req0_valid = v0;
      req0_data  = s0_d[(i0 < s0_n) ? i0 : 0];
      req0_last  = s0_l[(i0 < s0_n) ? i0 : 0];
      req1_valid = (i1 < s1_n);
      req1_data  = s1_d[(i1 < s1_n) ? i1 : 0];
      req1_last  = s1_l[(i1 < s1_n) ? i1 : 0];
      #1;
      if (pstall) chk({nm, "_stall_hold"}, cyc, {out_valid, out_src, out_last, 9'd0, out_data},
                      {1'b1, ps, pl, 9'd0, pd});
      if (out_valid && !out_ready) chk({nm, "_stall_rdy"}, cyc, {req0_ready, req1_ready}, 0);
      if (gap > 0) chk({nm, "_gap_hold"}, cyc, {req1_ready, busy}, 32'b01);
      if (out_valid && out_ready) begin
        if (got < e_n) begin
          ew = '0;
          ew[Q+7:Q] = e_dat[got];
          chk({nm, "_word"}, got, {out_src, out_last, 10'd0, out_data},
              {e_src[got], e_lst[got], 10'd0, ew});
        end else begin
          chk({nm, "_extra_word"}, got, 1, 0);
        end
        got++;
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      pstall = out_valid && !out_ready;
      pd = out_data; ps = out_src; pl = out_last;
      @(posedge clk);
      if (gap > 0 && !v0) gap--;
      if (a0) begin
        if (i0 == gap_at) gap = gap_len;
        i0++;
      end
      if (a1) i1++;
      cyc++;
    end
    chk({nm, "_done"}, 0, {got[7:0], i0[7:0], i1[7:0]},
        {e_n[7:0], s0_n[7:0], s1_n[7:0]});
    @(negedge clk);
    idle_inputs(); out_ready = 1;
  endtask

  initial begin
    int k;
    logic hit;
    rst = 1; out_ready = 1; idle_inputs();
    @(posedge clk); @(posedge clk);

    // rst r0v r0d r0l r1v r1d r1l ordy | r0rdy r1rdy ov od src last busy
    tbl[0]  = mk(0,0,8'h00,0, 0,8'h00,0,1, 0,0,0,20'h00000,0,0,0);
    tbl[1]  = mk(0,1,8'h05,1, 0,8'h00,0,1, 0,0,0,20'h00000,0,0,0);
    tbl[2]  = mk(0,1,8'h05,1, 0,8'h00,0,1, 1,0,0,20'h00000,0,0,1);
    tbl[3]  = mk(0,0,8'h00,0, 0,8'h00,0,1, 0,0,1,20'h02800,0,1,0);
    tbl[4]  = mk(0,0,8'h00,0, 0,8'h00,0,1, 0,0,0,20'h02800,0,1,0);
    tbl[5]  = mk(1,0,8'h00,0, 0,8'h00,0,1, 0,0,0,20'h02800,0,1,0);
    tbl[6]  = mk(0,0,8'h00,0, 0,8'h00,0,1, 0,0,0,20'h00000,0,0,0);
    tbl[7]  = mk(0,1,8'h01,0, 1,8'h10,0,1, 0,0,0,20'h00000,0,0,0);
    tbl[8]  = mk(0,1,8'h01,0, 1,8'h10,0,1, 1,0,0,20'h00000,0,0,1);
    tbl[9]  = mk(0,1,8'h02,0, 1,8'h10,0,1, 1,0,1,20'h00800,0,0,1);
    tbl[10] = mk(0,1,8'h03,1, 1,8'h10,0,1, 1,0,1,20'h01000,0,0,1);
    tbl[11] = mk(0,0,8'h00,0, 1,8'h10,0,1, 0,0,1,20'h01800,0,1,0);
    tbl[12] = mk(0,0,8'h00,0, 1,8'h10,0,1, 0,1,0,20'h01800,0,1,1);
    tbl[13] = mk(0,0,8'h00,0, 1,8'h20,0,1, 0,1,1,20'h08000,1,0,1);
    tbl[14] = mk(0,0,8'h00,0, 1,8'h30,1,1, 0,1,1,20'h10000,1,0,1);
    tbl[15] = mk(0,1,8'hFF,1, 1,8'h40,1,1, 0,0,1,20'h18000,1,1,0);
    tbl[16] = mk(0,1,8'hFF,1, 1,8'h40,1,1, 1,0,0,20'h18000,1,1,1);
    tbl[17] = mk(0,0,8'h00,0, 1,8'h40,1,1, 0,0,1,20'h7F800,0,1,0);
    tbl[18] = mk(0,0,8'h00,0, 1,8'h40,1,1, 0,1,0,20'h7F800,0,1,1);
    tbl[19] = mk(0,0,8'h00,0, 0,8'h00,0,1, 0,0,1,20'h20000,1,1,0);
    tbl[20] = mk(0,0,8'h00,0, 0,8'h00,0,1, 0,0,0,20'h20000,1,1,0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; out_ready = tbl[i].ordy;
      req0_valid = tbl[i].r0v; req0_data = tbl[i].r0d; req0_last = tbl[i].r0l;
      req1_valid = tbl[i].r1v; req1_data = tbl[i].r1d; req1_last = tbl[i].r1l;
      #1;
      chk("req0_ready", i, req0_ready, tbl[i].e0);
      chk("req1_ready", i, req1_ready, tbl[i].e1);
      chk("out_valid",  i, out_valid,  tbl[i].eov);
      chk("out_data",   i, out_data,   tbl[i].eod);
      chk("out_src",    i, out_src,    tbl[i].esrc);
      chk("out_last",   i, out_last,   tbl[i].elast);
      chk("busy",       i, busy,       tbl[i].ebusy);
    end
    @(negedge clk); rst = 0; idle_inputs();

    // backpressure: req1 burst of 4, out_ready 1,0,0,1,1,0,1,0,...
    clr();
    push1(8'hA1,0); push1(8'hA2,0); push1(8'hA3,0); push1(8'hA4,1);
    pushe(1,8'hA1,0); pushe(1,8'hA2,0); pushe(1,8'hA3,0); pushe(1,8'hA4,1);
    run_stream("bp", 8'b0101_1001, -1, 0);

    // forced release after MAX_BURST=4 beats, req1 waiting
    clr();
    for (int i = 0; i < 6; i++) push0(8'h61 + 8'(i), i == 5);
    push1(8'h77,1);
    pushe(0,8'h61,0); pushe(0,8'h62,0); pushe(0,8'h63,0); pushe(0,8'h64,1);
    pushe(1,8'h77,1); pushe(0,8'h65,0); pushe(0,8'h66,1);
    run_stream("force", 8'hFF, -1, 0);

    // gap mid-burst: req0 drops valid 5 cycles after its first beat
    do_reset();
    clr();
    push0(8'h81,0); push0(8'h82,0); push0(8'h83,1);
    push1(8'h91,1);
    pushe(0,8'h81,0); pushe(0,8'h82,0); pushe(0,8'h83,1); pushe(1,8'h91,1);
    run_stream("gap", 8'hFF, 0, 5);

    // reset mid-burst: set prio=1, stall a req1 word, then reset
    @(negedge clk);
    req0_valid = 1; req0_data = 8'h11; req0_last = 1; out_ready = 1;
    hit = 0;
    for (k = 0; k < 10 && !hit; k++) begin
      @(negedge clk); #1;
      if (req0_valid && req0_ready) hit = 1;
    end
    chk("rst_pre_accept0", 0, hit, 1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    out_ready = 0;
    req1_valid = 1; req1_data = 8'h22; req1_last = 0;
    hit = 0;
    for (k = 0; k < 10 && !hit; k++) begin
      @(negedge clk); #1;
      if (req1_valid && req1_ready) hit = 1;
    end
    chk("rst_pre_accept1", 0, hit, 1);
    @(negedge clk); #1;
    chk("rst_pre_state", 0, {out_valid, out_src, busy}, 3'b111);
    rst = 1; req0_valid = 1; req0_last = 0;
    @(posedge clk); #1;
    chk("rst_clear", 0, {out_valid, busy, req0_ready, req1_ready}, 0);
    chk("rst_data", 0, out_data, 0);
    @(negedge clk);
    rst = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("rst_prio0", 0, {req0_ready, req1_ready, busy}, 3'b101);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
